// File: rtl/jtkunio_pkg.sv
// Shared jtkunio constants: ROM region map, SDRAM bank offsets and download types.
package jtkunio_pkg;

  localparam logic [24:0] JTK_SND_START  = 25'h10000;
  localparam logic [24:0] JTK_PCM_START  = 25'h18000;
  localparam logic [24:0] JTK_CHAR_START = 25'h38000;
  localparam logic [24:0] JTK_SCR_START  = 25'h40000;
  localparam logic [24:0] JTK_OBJ_START  = 25'h60000;
  localparam logic [24:0] JTK_PROM_START = 25'hA0000;
  localparam logic [24:0] JTK_PROM_LEN   = 25'd512;

  localparam logic [21:0] JTK_MAIN_OFFSET = 22'h00000;
  localparam logic [21:0] JTK_SND_OFFSET  = 22'h08000;
  localparam logic [21:0] JTK_PCM_OFFSET  = 22'h0C000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_PROM
  } dwnld_state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } dwnld_entry_t;

endpackage

// File: rtl/jtkunio_dwnld_dec.sv
// Combinational ROM region decoder: byte address to SDRAM bank/word offset or PROM offset.
module jtkunio_dwnld_dec
  import jtkunio_pkg::*;
#(
  parameter logic [24:0] SND_START  = JTK_SND_START,
  parameter logic [24:0] PCM_START  = JTK_PCM_START,
  parameter logic [24:0] CHAR_START = JTK_CHAR_START,
  parameter logic [24:0] SCR_START  = JTK_SCR_START,
  parameter logic [24:0] OBJ_START  = JTK_OBJ_START,
  parameter logic [24:0] PROM_START = JTK_PROM_START
) (
  input  logic [24:0] addr,
  output logic [1:0]  ba,
  output logic [21:0] offset,
  output logic        is_prom,
  output logic        ignore
);

  localparam logic [24:0] PROM_END = PROM_START + JTK_PROM_LEN;

  logic [24:0] start;
  logic [21:0] base;
  logic [24:0] rel;

  always_comb begin
    start   = '0;
    base    = JTK_MAIN_OFFSET;
    ba      = 2'd0;
    is_prom = 1'b0;
    ignore  = 1'b0;
    if (addr < SND_START) begin
      start = '0;
    end else if (addr < PCM_START) begin
      start = SND_START;
      base  = JTK_SND_OFFSET;
    end else if (addr < CHAR_START) begin
      start = PCM_START;
      base  = JTK_PCM_OFFSET;
    end else if (addr < SCR_START) begin
      start = CHAR_START;
      ba    = 2'd1;
    end else if (addr < OBJ_START) begin
      start = SCR_START;
      ba    = 2'd2;
    end else if (addr < PROM_START) begin
      start = OBJ_START;
      ba    = 2'd3;
    end else if (addr < PROM_END) begin
      start   = PROM_START;
      is_prom = 1'b1;
    end else begin
      start  = PROM_START;
      ignore = 1'b1;
    end
    rel    = addr - start;
    // SDRAM word index is 25-bit arithmetic truncated to the 22-bit bank space
    offset = is_prom ? 22'(rel) : base + 22'(rel >> 1);
  end

endmodule

// File: rtl/jtkunio_dwnld.sv
// ROM download router: steers ioctl bytes to SDRAM banks or the MCU PROM,
// with a one-entry buffer to absorb strobes arriving during a write.
module jtkunio_dwnld
  import jtkunio_pkg::*;
#(
  parameter logic [24:0] SND_START  = JTK_SND_START,
  parameter logic [24:0] PCM_START  = JTK_PCM_START,
  parameter logic [24:0] CHAR_START = JTK_CHAR_START,
  parameter logic [24:0] SCR_START  = JTK_SCR_START,
  parameter logic [24:0] OBJ_START  = JTK_OBJ_START,
  parameter logic [24:0] PROM_START = JTK_PROM_START
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  input  logic        prog_ack,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_ba,
  output logic        prog_we,
  output logic        prom_we,
  output logic        dwnld_busy,
  output logic        dwnld_err
);

  dwnld_state_t state_q, state_d;
  dwnld_entry_t buf_q, buf_d;
  logic         buf_full_q, buf_full_d;
  logic         dl_prev_q;
  logic         err_q, err_d;
  logic [21:0]  prog_addr_q, prog_addr_d;
  logic [15:0]  prog_data_q, prog_data_d;
  logic [1:0]   prog_mask_q, prog_mask_d;
  logic [1:0]   prog_ba_q, prog_ba_d;
  logic         prog_we_q, prog_we_d;
  logic         prom_we_q, prom_we_d;

  logic        live, take_live, issue_buf, drop;
  logic [1:0]  l_ba, b_ba;
  logic [21:0] l_off, b_off;
  logic        l_prom, b_prom, l_ign, b_ign;

  jtkunio_dwnld_dec #(
    .SND_START (SND_START),
    .PCM_START (PCM_START),
    .CHAR_START(CHAR_START),
    .SCR_START (SCR_START),
    .OBJ_START (OBJ_START),
    .PROM_START(PROM_START)
  ) u_dec_live (
    .addr   (ioctl_addr),
    .ba     (l_ba),
    .offset (l_off),
    .is_prom(l_prom),
    .ignore (l_ign)
  );

  jtkunio_dwnld_dec #(
    .SND_START (SND_START),
    .PCM_START (PCM_START),
    .CHAR_START(CHAR_START),
    .SCR_START (SCR_START),
    .OBJ_START (OBJ_START),
    .PROM_START(PROM_START)
  ) u_dec_buf (
    .addr   (buf_q.addr),
    .ba     (b_ba),
    .offset (b_off),
    .is_prom(b_prom),
    .ignore (b_ign)
  );

  assign live = ioctl_wr & downloading;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      dl_prev_q   <= 1'b0;
      err_q       <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mask_q <= '1;
      prog_ba_q   <= '0;
      prog_we_q   <= 1'b0;
      prom_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      dl_prev_q   <= downloading;
      err_q       <= err_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_mask_q <= prog_mask_d;
      prog_ba_q   <= prog_ba_d;
      prog_we_q   <= prog_we_d;
      prom_we_q   <= prom_we_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    take_live  = 1'b0;
    issue_buf  = 1'b0;
    drop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The buffered byte is older, so it goes first; a new strobe refills the slot
        if (buf_full_q) begin
          issue_buf  = 1'b1;
          buf_full_d = 1'b0;
          if (!b_ign) state_d = b_prom ? ST_PROM : ST_WRITE;
        end else if (live) begin
          take_live = 1'b1;
          if (!l_ign) state_d = l_prom ? ST_PROM : ST_WRITE;
        end
      end
      ST_WRITE: if (prog_ack) state_d = ST_IDLE;
      ST_PROM:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (live && !take_live) begin
      if (buf_full_q && !issue_buf) begin
        drop = 1'b1;
      end else begin
        buf_d      = '{addr: ioctl_addr, data: ioctl_dout};
        buf_full_d = 1'b1;
      end
    end
    err_d = (err_q & ~(downloading & ~dl_prev_q)) | drop;
  end

  logic        sel_a0;
  logic [7:0]  sel_data;
  logic [1:0]  sel_ba;
  logic [21:0] sel_off;

  always_comb begin
    sel_a0      = issue_buf ? buf_q.addr[0] : ioctl_addr[0];
    sel_data    = issue_buf ? buf_q.data : ioctl_dout;
    sel_ba      = issue_buf ? b_ba : l_ba;
    sel_off     = issue_buf ? b_off : l_off;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prog_mask_d = prog_mask_q;
    prog_ba_d   = prog_ba_q;
    if (state_q == ST_IDLE && state_d == ST_PROM) begin
      prog_addr_d = sel_off;
      prog_data_d = {sel_data, sel_data};
      prog_mask_d = '1;
      prog_ba_d   = '0;
    end else if (state_q == ST_IDLE && state_d == ST_WRITE) begin
      prog_addr_d = sel_off;
      prog_data_d = {sel_data, sel_data};
      prog_mask_d = sel_a0 ? 2'b01 : 2'b10;
      prog_ba_d   = sel_ba;
    end
    prog_we_d = (state_d == ST_WRITE);
    prom_we_d = (state_d == ST_PROM);
  end

  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign prog_mask  = prog_mask_q;
  assign prog_ba    = prog_ba_q;
  assign prog_we    = prog_we_q;
  assign prom_we    = prom_we_q;
  assign dwnld_err  = err_q;
  assign dwnld_busy = !rst && (downloading || state_q != ST_IDLE || buf_full_q);

endmodule

// File: doc/jtkunio_dwnld.md
JTKUNIO_DWNLD -- requirements
Module: jtkunio_dwnld

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst; rst's polarity and synchronicity are fixed.
REQ-002 Parameter SND_START, default 25'h10000, byte address where sound CPU ROM begins.
REQ-003 Parameter PCM_START, default 25'h18000, byte address where PCM ROM begins.
REQ-004 Parameter CHAR_START, default 25'h38000, byte address where char ROM begins.
REQ-005 Parameter SCR_START, default 25'h40000, byte address where scroll ROM begins.
REQ-006 Parameter OBJ_START, default 25'h60000, byte address where object ROM begins.
REQ-007 Parameter PROM_START, default 25'hA0000, byte address where MCU PROM begins; the region is 512 bytes.
REQ-008 The ports SHALL be, one per line, as follows:
- clk  in  1  system clock, 48 MHz domain
- rst  in  1  async active-high reset
- downloading  in  1  ROM download in progress
- ioctl_addr  in  25  download byte address
- ioctl_dout  in  8  download byte
- ioctl_wr  in  1  one-cycle byte strobe
- prog_ack  in  1  SDRAM accepted current write
- prog_addr  out  22  word address within bank; bits [8:0] carry the PROM byte offset during prom_we
- prog_data  out  16  write data
- prog_mask  out  2  active-low byte enables
- prog_ba  out  2  SDRAM bank
- prog_we  out  1  SDRAM write request
- prom_we  out  1  MCU PROM write pulse
- dwnld_busy  out  1  download or flush pending
- dwnld_err  out  1  sticky byte-dropped flag

Function
REQ-009 Region decoding SHALL be as follows:
- addr < SND_START: main ROM, bank 0, offset 0.
- SND..PCM: bank 0, offset starting at word 22'h08000.
- PCM..CHAR: bank 0, offset starting at word 22'h0C000.
- CHAR..SCR: bank 1.
- SCR..OBJ: bank 2.
- OBJ..PROM: bank 3.
- PROM_START to PROM_START+511: PROM.
- Above PROM_START+511: ignored, no write.
REQ-010 For SDRAM regions, prog_addr SHALL be bank offset plus (ioctl_addr - region start) >> 1; all arithmetic is 25-bit and truncated to 22 bits.
REQ-011 prog_data SHALL be {ioctl_dout, ioctl_dout}.
REQ-012 prog_mask SHALL be 2'b10 when the byte offset is even (low byte) and 2'b01 when it is odd.
REQ-013 The FSM SHALL have states IDLE, WRITE and PROM.
REQ-014 In IDLE, a captured ioctl_wr with downloading=1 SHALL move to WRITE or PROM on the next cycle, per the decoded region; ignored addresses stay in IDLE.
REQ-015 In WRITE, prog_we SHALL be held high with address, data, mask and bank stable until the cycle prog_ack=1; the FSM returns to IDLE on the following edge and prog_we is low in that cycle.
REQ-016 In PROM, prom_we SHALL be high for exactly one cycle with prog_addr[8:0] = ioctl_addr - PROM_START, and prog_we SHALL stay low; the FSM then returns to IDLE.
REQ-017 One-entry pending buffer:
- An ioctl_wr arriving while not in IDLE SHALL be stored and issued immediately after the return to IDLE, with no idle cycle in between.
- An ioctl_wr arriving while the buffer is already full SHALL be discarded and SHALL set dwnld_err.
REQ-018 ioctl_wr coinciding with prog_ack SHALL go into the buffer; it is not dropped.
REQ-019 ioctl_wr with downloading=0 SHALL be ignored.
REQ-020 dwnld_busy SHALL be 1 while downloading=1, or while the FSM is not in IDLE, or while the buffer is full; it falls in the first cycle all three are clear.
REQ-021 dwnld_err SHALL clear only on the rising edge of downloading or on reset.

Reset
REQ-022 On rst, the block SHALL take these values asynchronously:
- FSM = IDLE and buffer empty.
- prog_we = 0 and prom_we = 0.
- prog_addr = 0, prog_data = 0, prog_mask = 2'b11, prog_ba = 0.
- dwnld_busy = 0 and dwnld_err = 0.
REQ-023 Reset asserted mid-WRITE SHALL abandon the write without waiting for prog_ack; a late prog_ack seen in IDLE SHALL be ignored.

Structure
REQ-024 The region start constants and bank offsets SHALL live in the shared jtkunio package, used by jtkunio_game and testbenches.
REQ-025 Region decode SHALL be one combinational sub-module, jtkunio_dwnld_dec (address in; bank, offset, is_prom and ignore out), instantiated twice: once for the live strobe and once for the buffered entry.

Verification
REQ-026 Byte 8'h5A at ioctl_addr 25'h00003, with ack after 3 cycles, SHALL produce prog_addr 1, mask 2'b01, ba 0 and data 16'h5A5A; prog_we is high for 4 cycles.
REQ-027 A byte at 25'h10002 SHALL produce ba 0 and prog_addr 22'h08001; a byte at 25'h40000 SHALL produce ba 2 and prog_addr 0; a byte at 25'h60005 SHALL produce ba 3, prog_addr 2 and mask 2'b01.
REQ-028 A byte 8'hC3 at 25'hA0010 SHALL produce one prom_we cycle with prog_addr[8:0] 9'h010, and prog_we SHALL stay 0; a byte at 25'hA0200 SHALL produce no writes.
REQ-029 Three strobes on consecutive cycles with ack held low SHALL result in the first in WRITE, the second buffered, the third dropped and dwnld_err=1; after the acks, exactly 2 SDRAM writes SHALL have occurred.
REQ-030 Lowering downloading during a pending write SHALL keep dwnld_busy=1 until the cycle after the ack, then drop it to 0.
REQ-031 Asserting rst during WRITE SHALL immediately force prog_we=0 and dwnld_busy=0, and a following prog_ack pulse SHALL cause no state change.
